// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Receive-side companion of the clock divider. Synchronises a slow divided
//   clock into the clk_in domain and produces one-cycle rise/fall strobes.
//   Measures the rising-to-rising period in clk_in cycles, reports lock and
//   flags a stalled divider.
//
//   Optional feature macro: PERIOD_CHECK_EN
//     defined   -> freq_ok reports whether the last period lies within
//                  EXP_PERIOD +/- TOL.
//     undefined -> freq_ok is tied to 0; EXP_PERIOD and TOL are unused.
module clk_period_monitor #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 200_000_000,
    parameter int unsigned EXP_PERIOD = 80_000_002,
    parameter int unsigned TOL        = 1_000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled,
    output logic             freq_ok
);

    // The gap counter only has to reach TIMEOUT, so it is sized from TIMEOUT
    // rather than CNT_W; this keeps narrow period counters usable with long
    // timeouts.
    localparam int unsigned GAP_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT);

    // Number of clk_in cycles after reset during which edges are ignored:
    // long enough for the 3-stage sync chain to fill with the real level.
    localparam logic [1:0] WU_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        STALL   = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Synchroniser and edge detection
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [1:0]       wu_q, wu_d;
    logic             edge_mask;
    logic             rise;
    logic             fall;
    logic             rise_pulse_q, rise_pulse_d;
    logic             fall_pulse_q, fall_pulse_d;

    // Gap (stall) detection
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             gap_hit;
    logic             timeout;

    // Period measurement and status
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] pcnt_inc;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             stalled_q, stalled_d;

    // Sync chain, warm-up masking and raw edge detection
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a value on
        // every path (here, unconditionally); a missed path infers a latch.
        s1_d      = slow_clk;
        s2_d      = s1_q;
        s3_d      = s2_q;
        wu_d      = (wu_q == WU_DONE) ? wu_q : wu_q + 2'd1;
        edge_mask = (wu_q != WU_DONE);
        rise      = s2_q & ~s3_q & ~edge_mask;
        fall      = ~s2_q & s3_q & ~edge_mask;
        rise_pulse_d = rise;
        fall_pulse_d = fall;
    end

    // Gap counter: cleared by any edge, otherwise counts up and sticks at TIMEOUT
    always_comb begin
        gap_hit = (gap_q == GAP_MAX);
        if (rise || fall) begin
            gap_d = '0;
        end else if (gap_hit) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + GAP_W'(1);
        end
        // An edge in the same cycle as the timeout wins: no stall is raised.
        timeout = gap_hit & ~(rise | fall);
    end

    // FSM state register
    always_ff @(posedge clk_in or posedge rst) begin
        // NOTE: clocked blocks use non-blocking assignments only, so every flop
        // samples the pre-edge value of its neighbours regardless of order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A gap timeout is meaningless before the first edge.
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE, LOCKED: begin
                if (rise) begin
                    state_d = LOCKED;
                end else if (timeout) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                // Recovery needs a fresh full period before lock is re-declared.
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: period counter, period capture and status flags
    always_comb begin
        pcnt_inc       = (pcnt_q == '1) ? pcnt_q : pcnt_q + CNT_W'(1);
        pcnt_d         = '0;
        period_d       = period_q;
        period_valid_d = 1'b0;
        case (state_q)
            IDLE, STALL: begin
                // The edge that starts a measurement counts as cycle 1; no
                // period is reported because none has been measured yet.
                if (rise) begin
                    pcnt_d = CNT_W'(1);
                end
            end
            MEASURE, LOCKED: begin
                if (rise) begin
                    period_d       = pcnt_q;
                    period_valid_d = 1'b1;
                    pcnt_d         = CNT_W'(1);
                end else if (!timeout) begin
                    pcnt_d = pcnt_inc;
                end
            end
            default: begin
                pcnt_d = '0;
            end
        endcase
        locked_d  = (state_d == LOCKED);
        stalled_d = (state_d == STALL);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            wu_q           <= 2'd0;
            rise_pulse_q   <= 1'b0;
            fall_pulse_q   <= 1'b0;
            gap_q          <= '0;
            pcnt_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            stalled_q      <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            wu_q           <= wu_d;
            rise_pulse_q   <= rise_pulse_d;
            fall_pulse_q   <= fall_pulse_d;
            gap_q          <= gap_d;
            pcnt_q         <= pcnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            stalled_q      <= stalled_d;
        end
    end

`ifdef PERIOD_CHECK_EN
    logic        freq_ok_q, freq_ok_d;
    logic [63:0] per_w;
    logic [63:0] exp_w;
    logic [63:0] diff_w;

    // Tolerance check on each new period; difference taken without wrap
    always_comb begin
        per_w  = 64'(period_d);
        exp_w  = 64'(EXP_PERIOD);
        diff_w = (per_w >= exp_w) ? (per_w - exp_w) : (exp_w - per_w);
        freq_ok_d = freq_ok_q;
        if (state_d == STALL) begin
            freq_ok_d = 1'b0;
        end else if (period_valid_d) begin
            freq_ok_d = (diff_w <= 64'(TOL));
        end
    end

    // freq_ok register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            freq_ok_q <= 1'b0;
        end else begin
            freq_ok_q <= freq_ok_d;
        end
    end

    assign freq_ok = freq_ok_q;
`else
    // Tolerance parameters have no function in this build.
    logic unused_cfg;
    assign unused_cfg = ^{EXP_PERIOD, TOL};
    assign freq_ok    = 1'b0;
`endif

    assign rise_pulse   = rise_pulse_q;
    assign fall_pulse   = fall_pulse_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign stalled      = stalled_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor.
// Main instance: CNT_W=16, TIMEOUT=50, EXP_PERIOD=20, TOL=1.
// Second instance with CNT_W=4 shares the stimulus to show period saturation.
// Inputs change on the falling edge of clk_in; outputs are sampled there too.
module tb_clk_period_monitor;

`ifdef PERIOD_CHECK_EN
    localparam logic FOK_EN = 1'b1;
`else
    localparam logic FOK_EN = 1'b0;
`endif

    logic        clk_in;
    logic        rst;
    logic        slow_clk;

    logic        rise_pulse;
    logic        fall_pulse;
    logic [15:0] period;
    logic        period_valid;
    logic        locked;
    logic        stalled;
    logic        freq_ok;

    logic        s_rise_pulse;
    logic        s_fall_pulse;
    logic [3:0]  s_period;
    logic        s_period_valid;
    logic        s_locked;
    logic        s_stalled;
    logic        s_freq_ok;

    int          checks = 0;
    int          errors = 0;
    logic        saw_rise;
    logic        saw_valid;

    clk_period_monitor #(
        .CNT_W      (16),
        .TIMEOUT    (50),
        .EXP_PERIOD (20),
        .TOL        (1)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .slow_clk     (slow_clk),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .stalled      (stalled),
        .freq_ok      (freq_ok)
    );

    clk_period_monitor #(
        .CNT_W      (4),
        .TIMEOUT    (50),
        .EXP_PERIOD (20),
        .TOL        (1)
    ) dut_sat (
        .clk_in       (clk_in),
        .rst          (rst),
        .slow_clk     (slow_clk),
        .rise_pulse   (s_rise_pulse),
        .fall_pulse   (s_fall_pulse),
        .period       (s_period),
        .period_valid (s_period_valid),
        .locked       (s_locked),
        .stalled      (s_stalled),
        .freq_ok      (s_freq_ok)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        rst       = 1'b1;
        slow_clk  = 1'b1;
        saw_rise  = 1'b0;
        saw_valid = 1'b0;

        // 1. slow_clk high through reset: no false edge, nothing happens
        step(3);
        check("rst_rise_pulse", rise_pulse, 0);
        check("rst_period", period, 0);
        check("rst_locked", locked, 0);
        check("rst_stalled", stalled, 0);
        check("rst_freq_ok", freq_ok, 0);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            saw_rise  = saw_rise | rise_pulse | s_rise_pulse;
            saw_valid = saw_valid | period_valid;
        end
        check("warmup_no_rise", saw_rise, 0);
        check("idle_no_valid", saw_valid, 0);
        check("idle_no_stall", stalled, 0);
        check("idle_not_locked", locked, 0);

        // 2. 10 high / 10 low square wave
        slow_clk = 1'b0;
        step(10);
        slow_clk = 1'b1;                          // rise A
        step(2);
        check("rise_lat_early", rise_pulse, 0);
        step(1);
        check("rise_lat_3", rise_pulse, 1);
        check("first_rise_no_valid", period_valid, 0);
        step(1);
        check("rise_one_cycle", rise_pulse, 0);
        step(6);
        slow_clk = 1'b0;
        step(3);
        check("fall_lat_3", fall_pulse, 1);
        step(7);
        slow_clk = 1'b1;                          // rise B, 20 after A
        step(3);
        check("p20_valid", period_valid, 1);
        check("p20_period", period, 20);
        check("p20_locked", locked, 1);
        check("p20_freq_ok", freq_ok, FOK_EN);
        check("sat_valid", s_period_valid, 1);
        check("sat_period", s_period, 15);
        step(1);
        check("p20_valid_one_cycle", period_valid, 0);
        check("p20_period_hold", period, 20);

        // 3. switch to 12 high / 12 low
        step(6);
        slow_clk = 1'b0;
        step(12);
        slow_clk = 1'b1;                          // rise C, 22 after B
        step(3);
        check("p22_period", period, 22);
        check("p22_freq_ok", freq_ok, 0);
        step(9);
        slow_clk = 1'b0;
        step(12);
        slow_clk = 1'b1;                          // rise D, 24 after C
        step(3);
        check("p24_valid", period_valid, 1);
        check("p24_period", period, 24);
        check("p24_freq_ok", freq_ok, 0);
        check("p24_locked", locked, 1);

        // 4. hold slow_clk: stall 51 edges after the rise-D pulse edge
        step(50);
        check("pre_stall_stalled", stalled, 0);
        check("pre_stall_locked", locked, 1);
        step(1);
        check("stall_stalled", stalled, 1);
        check("stall_locked", locked, 0);
        check("stall_freq_ok", freq_ok, 0);
        step(1);
        slow_clk = 1'b0;
        step(3);
        check("stall_fall_pulse", fall_pulse, 1);
        check("stall_kept_on_fall", stalled, 1);
        step(7);
        slow_clk = 1'b1;                          // rise ends the stall
        step(3);
        check("unstall_rise_pulse", rise_pulse, 1);
        check("unstall_stalled", stalled, 0);
        check("unstall_no_valid", period_valid, 0);
        check("unstall_locked", locked, 0);
        step(7);
        slow_clk = 1'b0;
        step(10);
        slow_clk = 1'b1;                          // first full period after stall
        step(3);
        check("relock_valid", period_valid, 1);
        check("relock_period", period, 20);
        check("relock_locked", locked, 1);
        check("relock_freq_ok", freq_ok, FOK_EN);

        // 5. edge lands exactly when gap reaches TIMEOUT
        step(7);
        slow_clk = 1'b0;
        step(51);
        slow_clk = 1'b1;
        step(3);
        check("coincide_rise", rise_pulse, 1);
        check("coincide_stalled", stalled, 0);
        check("coincide_locked", locked, 1);
        check("coincide_period", period, 61);
        step(1);
        check("coincide_stalled_after", stalled, 0);

        // 6. reset in the middle of a period
        step(5);
        rst = 1'b1;
        #1;
        check("midrst_period", period, 0);
        check("midrst_locked", locked, 0);
        check("midrst_stalled", stalled, 0);
        check("midrst_valid", period_valid, 0);
        check("midrst_freq_ok", freq_ok, 0);
        check("midrst_sat_period", s_period, 0);
        step(2);
        rst = 1'b0;
        step(5);
        check("postrst_no_rise", rise_pulse, 0);
        slow_clk = 1'b0;
        step(10);
        slow_clk = 1'b1;
        step(3);
        check("postrst_rise", rise_pulse, 1);
        check("postrst_no_partial", period_valid, 0);
        check("postrst_period_zero", period, 0);
        step(7);
        slow_clk = 1'b0;
        step(10);
        slow_clk = 1'b1;
        step(3);
        check("postrst_p20", period, 20);
        check("postrst_sat_valid", s_period_valid, 1);
        check("postrst_sat_p15", s_period, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
